// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for an RV32I subset core: sequences fetch, decode,
// execute, memory and write-back over a shared ALU and one shared memory port.
module mc_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic [1:0] wd_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [2:0] ext_op,
    output logic [2:0] state,
    output logic [1:0] trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_TRAP   = 3'b111
    } state_e;

    typedef struct packed {
        logic       legal;
        logic [2:0] op;
    } arith_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] EXT_NONE = 3'b000;
    localparam logic [2:0] EXT_S    = 3'b001;
    localparam logic [2:0] EXT_I    = 3'b010;
    localparam logic [2:0] EXT_B    = 3'b100;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam bit             WD_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WD_EN ? TIMEOUT - 1 : 0);

    // funct7_5 may only be set for SUB; this also rejects SRA/SRAI.
    function automatic arith_t arith_decode(input logic [2:0] f3, input logic f7,
                                            input logic is_r);
        arith_t r;
        r.legal = !f7;
        r.op    = ALU_ADD;
        case (f3)
            3'b000: begin
                r.legal = !f7 || is_r;
                r.op    = f7 ? ALU_SUB : ALU_ADD;
            end
            3'b001:  r.op = ALU_SLL;
            3'b010:  r.op = ALU_SLT;
            3'b100:  r.op = ALU_XOR;
            3'b101:  r.op = ALU_SRL;
            3'b110:  r.op = ALU_OR;
            3'b111:  r.op = ALU_AND;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [1:0]       cause_q, cause_d;

    logic   is_r, is_i, is_ld, is_st, is_br;
    logic   insn_legal, br_taken, wd_expire;
    arith_t arith;

    logic mem_req_c, ir_write_c, pc_write_c, reg_write_c;

    always_comb begin
        is_r       = (opcode == OP_R);
        is_i       = (opcode == OP_I);
        is_ld      = (opcode == OP_LD);
        is_st      = (opcode == OP_ST);
        is_br      = (opcode == OP_BR);
        arith      = arith_decode(funct3, funct7_5, is_r);
        insn_legal = ((is_r || is_i) && arith.legal)
                  || ((is_ld || is_st) && funct3 == 3'b010)
                  || (is_br && funct3[2:1] == 2'b00);
        br_taken   = funct3[0] ? !zero : zero;
        wd_expire  = WD_EN && (wd_cnt_q == CNT_LAST) && !mem_ready;
    end

    // NOTE: every output and next-state value gets a default before the case so
    // no path leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        wd_cnt_d    = wd_cnt_q;
        mem_req_c   = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        pc_src      = 1'b0;
        reg_write_c = 1'b0;
        wd_sel      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = ALU_ADD;
        ext_op      = EXT_NONE;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                alu_src_b = 2'b10;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (wd_expire) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                // Branch target (OldPC + B-imm) is parked in ALUOut here.
                alu_src_b = 2'b01;
                ext_op    = EXT_B;
                if (insn_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_FETCH;
                if (is_r) begin
                    alu_op  = arith.op;
                    state_d = S_WB;
                end else if (is_i) begin
                    alu_src_b = 2'b01;
                    ext_op    = EXT_I;
                    alu_op    = arith.op;
                    state_d   = S_WB;
                end else if (is_ld || is_st) begin
                    alu_src_b = 2'b01;
                    ext_op    = is_st ? EXT_S : EXT_I;
                    state_d   = S_MEM;
                end else if (is_br) begin
                    alu_op     = ALU_SUB;
                    pc_write_c = br_taken;
                    pc_src     = br_taken;
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                iord      = 1'b1;
                mem_we    = is_st;
                if (mem_ready) begin
                    state_d = is_ld ? S_WB : S_FETCH;
                end else if (wd_expire) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                wd_sel      = is_ld ? 2'b01 : 2'b00;
                state_d     = S_FETCH;
            end
            S_TRAP: begin
            end
            default: state_d = S_FETCH;
        endcase

        if (state_d != state_q) begin
            wd_cnt_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_FETCH;
            wd_cnt_q <= '0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state_q  <= state_d;
            wd_cnt_q <= wd_cnt_d;
            cause_q  <= cause_d;
        end
    end

    // Strobes are masked by rstn so nothing is written once reset asserts.
    assign mem_req    = mem_req_c & rstn;
    assign ir_write   = ir_write_c & rstn;
    assign pc_write   = pc_write_c & rstn;
    assign reg_write  = reg_write_c & rstn;
    assign state      = state_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: each instruction is expanded into its expected
// per-cycle output trace from the control rules, then compared cycle by cycle.
module tb_mc_ctrl;

    localparam int TO = 15;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] ST_F = 3'b000, ST_D = 3'b001, ST_E = 3'b010;
    localparam logic [2:0] ST_M = 3'b011, ST_W = 3'b100, ST_T = 3'b111;

    logic       clk = 1'b0;
    logic       rstn;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5, zero, mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] wd_sel, alu_src_b, trap_cause;
    logic       alu_src_a;
    logic [2:0] alu_op, ext_op, state;

    mc_ctrl #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rstn(rstn), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .wd_sel(wd_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .ext_op(ext_op), .state(state), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write;
        logic [1:0] wd_sel;
        logic       a;
        logic [1:0] b;
        logic [2:0] aop;
        logic [2:0] ext;
        logic [1:0] cause;
    } cyc_t;

    cyc_t exp_q[$];
    logic rdy_q[$];

    int n_vec = 0;
    int n_err = 0;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7, cur_z;
    bit         in_trap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c    = '0;
        c.st = st;
        return c;
    endfunction

    task automatic push(input cyc_t c, input logic r);
        exp_q.push_back(c);
        rdy_q.push_back(r);
    endtask

    task automatic push_trap(input logic [1:0] cause);
        cyc_t c;
        for (int i = 0; i < 3; i++) begin
            c       = blank(ST_T);
            c.cause = cause;
            push(c, 1'($urandom));
        end
    endtask

    // RV32I meaning of funct3 for register/immediate arithmetic.
    function automatic logic [2:0] alu_code(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? 3'b001 : 3'b000;  // ADD / SUB
            3'd1:    return 3'b101;                 // SLL
            3'd2:    return 3'b111;                 // SLT
            3'd4:    return 3'b100;                 // XOR
            3'd5:    return 3'b110;                 // SRL
            3'd6:    return 3'b011;                 // OR
            3'd7:    return 3'b010;                 // AND
            default: return 3'b000;
        endcase
    endfunction

    // Expected trace for one instruction with fw/mw wait cycles before mem_ready.
    task automatic build(input int fw, input int mw);
        cyc_t c;
        bit   arith, ok, ld, st;
        arith = (cur_op == OP_R) || (cur_op == OP_I);
        ld    = (cur_op == OP_LD);
        st    = (cur_op == OP_ST);
        for (int i = 0; i < fw && i < TO; i++) begin
            c = blank(ST_F); c.mem_req = 1; c.b = 2'b10;
            push(c, 1'b0);
        end
        if (fw >= TO) begin push_trap(2'b10); return; end
        c = blank(ST_F); c.mem_req = 1; c.b = 2'b10; c.ir_write = 1; c.pc_write = 1;
        push(c, 1'b1);
        c = blank(ST_D); c.b = 2'b01; c.ext = 3'b100;
        push(c, 1'($urandom));

        if (arith)           ok = (cur_f3 != 3'd3) && (!cur_f7 || (cur_op == OP_R && cur_f3 == 3'd0));
        else if (ld || st)   ok = (cur_f3 == 3'd2);
        else if (cur_op == OP_BR) ok = (cur_f3 <= 3'd1);
        else                 ok = 0;
        if (!ok) begin push_trap(2'b01); return; end

        c = blank(ST_E); c.a = 1;
        if (arith) begin
            c.aop = alu_code(cur_f3, cur_f7);
            if (cur_op == OP_I) begin c.b = 2'b01; c.ext = 3'b010; end
        end else if (ld) begin
            c.b = 2'b01; c.ext = 3'b010;
        end else if (st) begin
            c.b = 2'b01; c.ext = 3'b001;
        end else begin
            c.aop      = 3'b001;
            c.pc_write = (cur_f3 == 3'd0) ? cur_z : !cur_z;
            c.pc_src   = c.pc_write;
            push(c, 1'($urandom));
            return;
        end
        push(c, 1'($urandom));

        if (ld || st) begin
            for (int i = 0; i < mw && i < TO; i++) begin
                c = blank(ST_M); c.mem_req = 1; c.iord = 1; c.mem_we = st;
                push(c, 1'b0);
            end
            if (mw >= TO) begin push_trap(2'b10); return; end
            c = blank(ST_M); c.mem_req = 1; c.iord = 1; c.mem_we = st;
            push(c, 1'b1);
            if (st) return;
        end
        c = blank(ST_W); c.reg_write = 1; c.wd_sel = ld ? 2'b01 : 2'b00;
        push(c, 1'($urandom));
    endtask

    // Entered and left at the drive slot, 2 time units after a rising edge.
    task automatic run_trace(input int limit);
        cyc_t e, got;
        int   n;
        n = exp_q.size();
        if (limit < n) n = limit;
        for (int i = 0; i < n; i++) begin
            e         = exp_q[i];
            mem_ready = rdy_q[i];
            if (e.st == ST_F) begin
                opcode = 7'($urandom); funct3 = 3'($urandom); funct7_5 = 1'($urandom);
            end else begin
                opcode = cur_op; funct3 = cur_f3; funct7_5 = cur_f7;
            end
            zero = (e.st == ST_E) ? cur_z : 1'($urandom);
            @(negedge clk);
            got = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
                   wd_sel, alu_src_a, alu_src_b, alu_op, ext_op, trap_cause};
            check($sformatf("op%b_cyc%0d_st%0d", cur_op, i, e.st), 32'(got), 32'(e));
            in_trap = (e.st == ST_T);
            @(posedge clk);
            #2;
        end
        exp_q.delete();
        rdy_q.delete();
    endtask

    task automatic do_reset(input int cycles);
        mem_ready = 1'b1;
        rstn      = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check($sformatf("reset_cyc%0d", i),
                  32'({state, mem_req, ir_write, pc_write, reg_write, trap_cause}), 32'd0);
            @(posedge clk);
            #2;
        end
        mem_ready = 1'b0;
        rstn      = 1'b1;
        in_trap   = 0;
    endtask

    task automatic run_insn(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input int fw, input int mw);
        cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z;
        build(fw, mw);
        run_trace(1000);
        if (in_trap) do_reset(2);
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)  return $urandom_range(0, 2);
        if (r == 7) return TO - 1;
        if (r == 8) return TO;
        return $urandom_range(0, 20);
    endfunction

    initial begin
        rstn = 1'b0; mem_ready = 1'b0; opcode = '0; funct3 = '0;
        funct7_5 = 1'b0; zero = 1'b0; in_trap = 0;
        @(posedge clk);
        #2;
        do_reset(2);

        run_insn(OP_R,  3'd0, 1'b0, 1'b0, 0, 0);     // ADD
        run_insn(OP_R,  3'd0, 1'b1, 1'b0, 0, 0);     // SUB
        run_insn(OP_I,  3'd6, 1'b0, 1'b0, 1, 0);     // ORI
        run_insn(OP_LD, 3'd2, 1'b0, 1'b0, 0, 3);     // LW, MEM held 4 cycles
        run_insn(OP_ST, 3'd2, 1'b0, 1'b0, 0, 0);     // SW
        run_insn(OP_BR, 3'd1, 1'b0, 1'b0, 0, 0);     // BNE taken
        run_insn(OP_BR, 3'd0, 1'b0, 1'b0, 0, 0);     // BEQ not taken
        run_insn(OP_BR, 3'd0, 1'b0, 1'b1, 0, 0);     // BEQ taken
        run_insn(7'h7f, 3'd0, 1'b0, 1'b0, 0, 0);     // illegal opcode
        run_insn(OP_R,  3'd5, 1'b1, 1'b0, 0, 0);     // SRA illegal
        run_insn(OP_R,  3'd0, 1'b0, 1'b0, 40, 0);    // fetch timeout
        run_insn(OP_R,  3'd4, 1'b0, 1'b0, TO - 1, 0); // ready on last count wins
        run_insn(OP_LD, 3'd2, 1'b0, 1'b0, 0, TO - 1);
        run_insn(OP_ST, 3'd2, 1'b0, 1'b0, 0, 30);    // memory timeout

        // Reset asserted while waiting in MEM.
        cur_op = OP_LD; cur_f3 = 3'd2; cur_f7 = 1'b0; cur_z = 1'b0;
        build(0, 10);
        run_trace(7);
        do_reset(3);
        run_insn(OP_R, 3'd7, 1'b0, 1'b0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic       f7;
            f3 = 3'($urandom);
            f7 = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0: op = OP_R;
                1: op = OP_I;
                2: begin op = OP_LD; if ($urandom_range(0, 3) != 0) f3 = 3'd2; end
                3: begin op = OP_ST; if ($urandom_range(0, 3) != 0) f3 = 3'd2; end
                4: begin op = OP_BR; if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1)); end
                default: op = 7'($urandom);
            endcase
            run_insn(op, f3, f7, 1'($urandom), pick_wait(), pick_wait());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the RV32I subset core.
- Sequences instruction fetch, decode, execute, memory and write-back over a shared ALU and a single shared memory port.
- Drives every datapath select, including the immediate-extender opcode ext_op.
- Handles a ready-based memory handshake with a wait-timeout watchdog and a trap state.

Parameters:
- TIMEOUT, 15, max cycles to wait for mem_ready in FETCH/MEM before trapping; 0 disables the watchdog.
- CNT_W, 4, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0], stable from the cycle after ir_write
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  1=store, 0=read; valid only with mem_req
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  load IR and OldPC from memory data and PC
- pc_write  out  1  PC update strobe
- pc_src  out  1  PC source: 0=ALU result, 1=ALUOut register
- reg_write  out  1  register file write strobe
- wd_sel  out  2  write-back data: 00=ALUOut, 01=MDR
- alu_src_a  out  1  0=OldPC/PC (FETCH uses PC), 1=rs1
- alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT
- ext_op  out  3  010 I-type, 001 S-type, 100 B-type, 000 none
- state  out  3  current state, for debug
- trap_cause  out  2  00 none, 01 illegal instruction, 10 memory timeout

Behaviour:
- Clocking and reset: one clock (clk); reset rstn is asynchronous, active-low.
- Reset values: state=FETCH (000), trap_cause=00, watchdog count=0. While rstn=0, all strobes (mem_req, ir_write, pc_write, reg_write) are forced to 0.
- Output timing: all outputs are combinational from state plus inputs. Any output not listed for a state is 0.
- FETCH (000):
  - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=10, alu_op=ADD.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0; go to DECODE.
- DECODE (001):
  - Drives alu_src_a=0 (OldPC), alu_src_b=01, ext_op=100, alu_op=ADD, so the branch target lands in ALUOut.
  - Legal opcodes: 0110011, 0010011, 0000011 (funct3=010), 0100011 (funct3=010), 1100011 (funct3 000/001).
  - R/I-type legal when funct3/funct7_5 maps to an alu_op. funct7_5=1 is legal only for R-type funct3=000 (SUB). SRA/SRAI are illegal.
  - Legal instruction -> EXEC. Otherwise -> TRAP with trap_cause=01.
- EXEC (010):
  - R-type: alu_src_a=1, alu_src_b=00, alu_op per funct3/funct7_5; -> WB.
  - I-arith: alu_src_a=1, alu_src_b=01, ext_op=010; -> WB.
  - Load: as I-arith with alu_op=ADD; -> MEM.
  - Store: alu_src_a=1, alu_src_b=01, ext_op=001, alu_op=ADD; -> MEM.
  - Branch: alu_src_a=1, alu_src_b=00, alu_op=SUB. Taken = (funct3=000 & zero) | (funct3=001 & !zero). If taken, pc_write=1 and pc_src=1. -> FETCH.
- MEM (011):
  - Drives mem_req=1, iord=1, mem_we=1 for store.
  - Waits for mem_ready, then: load -> WB, store -> FETCH.
- WB (100): reg_write=1; wd_sel=01 for load, else 00; -> FETCH.
- TRAP (111): all strobes 0; held until reset; trap_cause is held.
- Watchdog:
  - Count clears on every state change.
  - Increments each FETCH/MEM cycle with mem_ready=0.
  - If count==TIMEOUT-1 and mem_ready=0 (TIMEOUT≠0) -> TRAP, trap_cause=10.
  - mem_ready in the same cycle as expiry wins: normal transition, no trap.
- Reset mid-operation (any state, including mid-wait) immediately returns to FETCH with strobes low. No partial write occurs after rstn falls.
- Latencies with zero-wait memory:
  - R/I: 4 cycles
  - Load: 5 cycles
  - Store: 4 cycles
  - Branch: 3 cycles

Test Plan:
- Reset: rstn low for 3 cycles mid-MEM -> state=000, mem_req=0, reg_write=0. Release -> mem_req=1, iord=0 on the next cycle.
- ADD x3,x1,x2 (0110011/000/0) with mem_ready=1 -> states 000,001,010,100. In EXEC alu_op=000, alu_src_b=00. reg_write=1 in exactly one cycle.
- LW (0000011/010) with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles, iord=1, mem_we=0, ext_op=010 in EXEC, WB wd_sel=01.
- SW (0100011/010) -> EXEC ext_op=001; MEM mem_we=1; returns to FETCH with no reg_write.
- BNE with zero=0 -> EXEC pc_write=1, pc_src=1. BEQ with zero=0 -> no pc_write. DECODE ext_op=100 in both.
- Opcode 1111111 -> TRAP, trap_cause=01. Separately, mem_ready held low in FETCH with TIMEOUT=15 -> TRAP after exactly 15 cycles, trap_cause=10.
